// File: rtl/maybe_pkg.sv
// Shared types and helpers for the Maybe delay line.
// maybe_t is the default-width (8-bit payload) Maybe encoding. Modules
// with a different payload width declare the same layout locally.
package maybe_pkg;

  localparam int MAYBE_W = 8;

  typedef struct packed {
    logic               valid;
    logic [MAYBE_W-1:0] data;
  } maybe_t;

  // Canonical Nothing: valid clear and an all-zero payload.
  function automatic maybe_t nothing();
    maybe_t m;
    m = '0;
    return m;
  endfunction

  // Increment v, saturating at 2^cw - 1. The 32-bit container lets one
  // helper serve any counter width up to 32 bits; callers truncate.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int cw);
    logic [31:0] max_v;
    if (cw >= 32) begin
      max_v = '1;
    end else begin
      max_v = (32'd1 << cw) - 32'd1;
    end
    if (v >= max_v) begin
      return max_v;
    end
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/maybe_stage.sv
// One Maybe register with enable and synchronous active-high reset.
// Captured values are kept canonical: a Nothing is always stored with an
// all-zero payload, so the last stage can drive the outputs directly.
module maybe_stage
  import maybe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         vld_q;
  logic         vld_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next state: load the (canonicalised) input when enabled, else hold.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (en_i) begin
      vld_d  = vld_i;
      data_d = vld_i ? data_i : '0;
    end
  end

  // Stage register; reset clears both the valid bit and the payload so no
  // stale data survives a mid-stream reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/maybe_delay_pipe.sv
// DEPTH-stage delay line for Maybe streams (valid + W-bit payload) with a
// global stall, an occupancy counter and a saturating drop counter.
// Optional feature macro: SIG_HOLD_LAST_EN -- when defined, __out1 shows the
// last valid payload that left the pipe while __out0 is low, instead of 0.
// All outputs come straight from registers; there is no input-to-output
// combinational path.
module maybe_delay_pipe
  import maybe_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 3,
  parameter int CW    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         __in0,
  input  logic [W-1:0]                 __in1,
  input  logic                         __in2,
  output logic                         __out0,
  output logic [W-1:0]                 __out1,
  output logic [$clog2(DEPTH+1)-1:0]   __out2,
  output logic [CW-1:0]                __out3
);

  localparam int OW = $clog2(DEPTH+1);

  // Advance when not stalled; every stage shares this enable.
  logic adv;
  assign adv = !__in2;

  logic [DEPTH-1:0]        vld_s;
  logic [DEPTH-1:0][W-1:0] data_s;

  logic         tail_vld;
  logic [W-1:0] tail_data;
  assign tail_vld  = vld_s[DEPTH-1];
  assign tail_data = data_s[DEPTH-1];

  // Stage chain: stage 0 takes the input, stage i takes stage i-1.
  for (genvar i = 0; i < DEPTH; i++) begin : gen_stage
    if (i == 0) begin : g_head
      maybe_stage #(.W(W)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .en_i   (adv),
        .vld_i  (__in0),
        .data_i (__in1),
        .vld_o  (vld_s[i]),
        .data_o (data_s[i])
      );
    end else begin : g_body
      maybe_stage #(.W(W)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .en_i   (adv),
        .vld_i  (vld_s[i-1]),
        .data_i (data_s[i-1]),
        .vld_o  (vld_s[i]),
        .data_o (data_s[i])
      );
    end
  end

  // Saturating drop-counter step, kept separate from the counter logic.
  function automatic logic [CW-1:0] drop_step(input logic [CW-1:0] v);
    logic [31:0] wide;
    wide = sat_inc(32'(v), CW);
    return wide[CW-1:0];
  endfunction

  logic          enter;
  logic          leave;
  logic [OW-1:0] occ_q;
  logic [OW-1:0] occ_d;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] drop_d;

  assign enter = adv & __in0;
  assign leave = adv & tail_vld;

  // Counter next state: occupancy tracks enters minus exits; a Just that
  // arrives during a stall is lost and counted.
  always_comb begin
    occ_d  = occ_q + OW'(enter) - OW'(leave);
    drop_d = drop_q;
    if (__in2 && __in0) begin
      drop_d = drop_step(drop_q);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= '0;
      drop_q <= '0;
    end else begin
      occ_q  <= occ_d;
      drop_q <= drop_d;
    end
  end

  assign __out0 = tail_vld;
  assign __out2 = occ_q;
  assign __out3 = drop_q;

`ifdef SIG_HOLD_LAST_EN
  logic [W-1:0] hold_q;
  logic [W-1:0] hold_d;

  // Remember the payload of each valid value as it leaves the pipe.
  always_comb begin
    hold_d = hold_q;
    if (leave) begin
      hold_d = tail_data;
    end
  end

  // Hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign __out1 = tail_vld ? tail_data : hold_q;
`else
  // Stages store Nothing with a zero payload, so the tail is already canonical.
  assign __out1 = tail_data;
`endif

endmodule
